// File: rtl/mux16_pkg.sv
// rtl/mux16_pkg.sv - shared types, widths and helpers for the 16:1 scan transmitter
package mux16_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_PAR  = 2'd3
    } state_t;

    // The remote demux expects the slot number with its bit order flipped.
    function automatic logic [SEL_W-1:0] bitrev4(input logic [SEL_W-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/mux16_scan_tx_slot_timer.sv
// rtl/mux16_scan_tx_slot_timer.sv - cycle-within-slot and slot counters for the scan transmitter
module slot_timer
    import mux16_pkg::*;
#(
    parameter int SLOT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    output logic [SEL_W-1:0] k,
    output logic             slot_end,
    output logic             frame_end
);

    logic [7:0] c;

    assign slot_end  = run && (c == 8'(SLOT_CYCLES - 1));
    assign frame_end = slot_end && (k == LAST_SLOT);

    // Count cycles inside a slot; step to the next slot when the hold time is used up.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            c <= '0;
            k <= '0;
        end else if (run) begin
            if (slot_end) begin
                c <= '0;
                k <= k + 1'b1;
            end else begin
                c <= c + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mux16_scan_tx.sv
// rtl/mux16_scan_tx.sv - 16:1 time-division transmitter with select/strobe for the remote demux; PARITY_EN adds a parity slot
module mux16_scan_tx
    import mux16_pkg::*;
#(
    parameter int SLOT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] D,
    output logic [SEL_W-1:0]  S,
    output logic              Y,
    output logic              E,
    output logic              busy,
    output logic              done
);

    state_t            state;
    logic [WORD_W-1:0] shadow;
    logic [SEL_W-1:0]  k;
    logic [SEL_W-1:0]  k_next;
    logic              slot_end;
    logic              frame_end;
    logic              tmr_clear;
    logic              tmr_run;

    assign tmr_run   = (state == ST_SEND) || (state == ST_PAR);
    assign tmr_clear = (state == ST_IDLE) || (state == ST_DONE);
    assign k_next    = k + 1'b1;

    slot_timer #(
        .SLOT_CYCLES(SLOT_CYCLES)
    ) u_slot_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .run      (tmr_run),
        .k        (k),
        .slot_end (slot_end),
        .frame_end(frame_end)
    );

    // Frame sequencer; outputs are loaded one cycle ahead so they change only at slot boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            shadow <= '0;
            S      <= '0;
            Y      <= 1'b0;
            E      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= ST_SEND;
                        shadow <= D;
                        S      <= bitrev4('0);
                        Y      <= D[WORD_W-1];
                        E      <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (slot_end) begin
                        if (frame_end) begin
`ifdef PARITY_EN
                            state <= ST_PAR;
                            S     <= '0;
                            Y     <= ^shadow;
                            E     <= 1'b0;
`else
                            state <= ST_DONE;
                            S     <= '0;
                            Y     <= 1'b0;
                            E     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end else begin
                            S <= bitrev4(k_next);
                            Y <= shadow[LAST_SLOT - k_next];
                        end
                    end
                end
                ST_PAR: begin
                    if (slot_end) begin
                        state <= ST_DONE;
                        S     <= '0;
                        Y     <= 1'b0;
                        E     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_scan_tx.sv
// tb/tb_mux16_scan_tx.sv - scoreboard bench for mux16_scan_tx at slot lengths 4, 1 and 2
module tb_mux16_scan_tx;

`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] s;
        logic       y;
        logic       e;
        logic       busy;
        logic       done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] d;

    logic [3:0] s4, s1, s2;
    logic       y4, y1, y2, e4, e1, e2, b4, b1, b2, dn4, dn1, dn2;

    int   checks = 0;
    int   errors = 0;
    int   sel    = 0;
    obs_t obs;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    mux16_scan_tx #(.SLOT_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .D(d),
        .S(s4), .Y(y4), .E(e4), .busy(b4), .done(dn4)
    );

    mux16_scan_tx #(.SLOT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .D(d),
        .S(s1), .Y(y1), .E(e1), .busy(b1), .done(dn1)
    );

    mux16_scan_tx #(.SLOT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .D(d),
        .S(s2), .Y(y2), .E(e2), .busy(b2), .done(dn2)
    );

    always_comb begin
        case (sel)
            1:       obs = {s1, y1, e1, b1, dn1};
            2:       obs = {s2, y2, e2, b2, dn2};
            default: obs = {s4, y4, e4, b4, dn4};
        endcase
    end

    function automatic logic [3:0] rev(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic push_frame(input logic [15:0] w, input int sc);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] kk;
            kk = k[3:0];
            for (int c = 0; c < sc; c++)
                exp_q.push_back({rev(kk), w[15-k], 1'b1, 1'b1, 1'b0});
        end
        if (PAR)
            for (int c = 0; c < sc; c++)
                exp_q.push_back({4'b0000, ^w, 1'b0, 1'b1, 1'b0});
        exp_q.push_back({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic settle();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Sends one frame and compares every cycle up to and including the done pulse.
    task automatic run_frame(input string name, input int dsel, input int sc,
                             input logic [15:0] w, input int restart_at, input logic [15:0] w2);
        int   n;
        obs_t e;
        sel = dsel;
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s idle_before_start got %b want %b", name, obs, 8'b0);
        end
        start = 1'b1;
        d     = w;
        push_frame(w, sc);
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = (n + 1 == restart_at);
            d     = start ? w2 : ~w;
            e     = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cycle %0d got s=%b y=%b e=%b busy=%b done=%b want s=%b y=%b e=%b busy=%b done=%b",
                         name, n + 1, obs.s, obs.y, obs.e, obs.busy, obs.done,
                         e.s, e.y, e.e, e.busy, e.done);
            end
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        d     = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_values dut%0d got %b want %b", i, obs, 8'b0);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_walking_one();
        run_frame("walk_one", 0, 4, 16'h8000, 0, 16'h0000);
    endtask

    task automatic test_ignore_busy_back_to_back();
        run_frame("ignore_busy", 0, 4, 16'h00FF, 1 + 7 * 4, 16'hFF00);
        run_frame("back_to_back", 0, 4, 16'h3C5A, 0, 16'h0000);
    endtask

    task automatic test_mid_reset();
        int saw_done;
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        d     = 16'hBEEF;
        repeat (1 + 5 * 4) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (s4 !== rev(4'd5) || e4 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_slot5 got s=%b e=%b want s=%b e=1", s4, e4, rev(4'd5));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b want %b", obs, 8'b0);
        end
        saw_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (dn4) saw_done++;
        end
        checks++;
        if (saw_done != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done got %0d pulses want 0", saw_done);
        end
        run_frame("after_reset", 0, 4, 16'h6B2D, 0, 16'h0000);
    endtask

    // The remote demux routes Y to line 15-k, with k recovered by flipping S back.
    task automatic test_loopback(input logic [15:0] w);
        logic [15:0] cap;
        logic [3:0]  kk;
        int          cyc;
        bit          got_done;
        sel      = 1;
        cap      = ~w;
        got_done = 0;
        @(negedge clk);
        start = 1'b1;
        d     = w;
        for (cyc = 0; cyc < 40 && !got_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (e1) begin
                kk = rev(s1);
                cap[4'd15 - kk] = y1;
            end
            if (dn1) got_done = 1;
        end
        checks++;
        if (!got_done || cap !== w) begin
            errors++;
            $display("FAIL loopback done=%0d got %h want %h", got_done, cap, w);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        d     = '0;
        test_reset();
        test_walking_one();
        settle();
        test_ignore_busy_back_to_back();
        settle();
        test_mid_reset();
        settle();
        test_loopback(16'hA5C3);
        settle();
        test_loopback(16'h0001);
        settle();
        test_loopback(16'hFFFF);
        settle();
        test_loopback(16'h1234);
        settle();
        if (PAR) begin
            run_frame("parity_0007", 2, 2, 16'h0007, 0, 16'h0000);
            settle();
            run_frame("parity_0003", 2, 2, 16'h0003, 0, 16'h0000);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
